// File: rtl/prog_loader.sv
// prog_loader: host valid/ready byte stream -> program RAM 0..DEPTH-1 with trailing checksum; outputs RAM write port, cpu_hold, busy/done/err, count
module prog_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CSUM, DONE, ERR} state_t;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  state_t            state_q;
  logic              in_ready_q, ram_we_q, cpu_hold_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q, sum_q, sum_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              xfer;
  assign xfer    = in_valid && in_ready_q;
  assign sum_d   = sum_q + in_data;
  assign count_d = count_q + 1'b1;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      ram_we_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      count_q    <= '0;
      sum_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: if (start) begin
          state_q    <= LOAD;
          count_q    <= '0;
          sum_q      <= '0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          in_ready_q <= 1'b1;
          cpu_hold_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        LOAD: if (xfer) begin
          state_q    <= WRITE;
          ram_addr_q <= count_q[ADDR_W-1:0];
          ram_data_q <= in_data;
          sum_q      <= sum_d;
          in_ready_q <= 1'b0;
          ram_we_q   <= 1'b1;
        end
        WRITE: begin
          ram_we_q   <= 1'b0;
          in_ready_q <= 1'b1;
          count_q    <= count_d;
          state_q    <= (count_d == DEPTH_C) ? CSUM : LOAD;
        end
        CSUM: if (xfer) begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          if (sum_d == '0) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= ERR;
            err_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a RAM-write monitor
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       clr, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ram_we, cpu_hold, busy, done, err;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic [4:0] count;
  int         total = 0, bad = 0, cyc = 0, n_wr = 0, overlap = 0, t0 = 0, t1 = 0;
  logic [3:0] wr_addr [64];
  logic [7:0] wr_data [64];
  prog_loader dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_we && n_wr < 64) begin
      wr_addr[n_wr] = ram_addr;
      wr_data[n_wr] = ram_data;
      n_wr++;
    end
    if (ram_we && in_ready) overlap++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      got = in_ready;
      tick();
    end
    if (!got) chk("send_timeout", {31'd0, got}, 32'd1);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask
  task automatic load(input logic [7:0] base, input logic [7:0] step, input logic [7:0] cs,
                      input bit gaps, input bit sp);
    n_wr = 0;
    for (int i = 0; i < 16; i++) begin
      start = sp && i >= 4 && i < 7;
      send(8'(int'(base) + int'(step) * i), gaps ? int'($urandom_range(0, 3)) : 0);
      if (i == 0) t0 = cyc;
    end
    start = 1'b0;
    send(cs, 0);
    t1 = cyc;
    in_valid = 1'b0;
  endtask
  task automatic verify(input logic [7:0] base, input logic [7:0] step);
    chk("n_writes", n_wr, 16);
    chk("overlap", overlap, 0);
    for (int i = 0; i < 16 && i < n_wr; i++) begin
      chk($sformatf("addr%0d", i), {28'd0, wr_addr[i]}, i);
      chk($sformatf("data%0d", i), {24'd0, wr_data[i]}, {24'd0, 8'(int'(base) + int'(step) * i)});
    end
  endtask
  initial begin
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    clr = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_addr", {28'd0, ram_addr}, 0);
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) tick();
    chk("idle_writes", n_wr, 0);
    chk("idle_in_ready", {31'd0, in_ready}, 0);
    chk("idle_cpu_hold", {31'd0, cpu_hold}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    in_valid = 1'b0;
    pulse_start();
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_hold", {31'd0, cpu_hold}, 1);
    chk("start_ready", {31'd0, in_ready}, 1);
    load(8'h00, 8'h01, 8'h88, 1'b0, 1'b1);
    verify(8'h00, 8'h01);
    chk("good_done", {31'd0, done}, 1);
    chk("good_err", {31'd0, err}, 0);
    chk("good_hold", {31'd0, cpu_hold}, 0);
    chk("good_busy", {31'd0, busy}, 0);
    chk("good_count", {27'd0, count}, 16);
    chk("good_cycles", t1 - t0 + 1, 33);
    pulse_start();
    chk("restart_done", {31'd0, done}, 0);
    load(8'h00, 8'h01, 8'h87, 1'b0, 1'b0);
    chk("bad_writes", n_wr, 16);
    chk("bad_err", {31'd0, err}, 1);
    chk("bad_done", {31'd0, done}, 0);
    chk("bad_hold", {31'd0, cpu_hold}, 1);
    chk("bad_busy", {31'd0, busy}, 0);
    chk("bad_ready", {31'd0, in_ready}, 0);
    pulse_start();
    chk("err_restart_err", {31'd0, err}, 0);
    chk("err_restart_hold", {31'd0, cpu_hold}, 1);
    chk("err_restart_busy", {31'd0, busy}, 1);
    chk("err_restart_count", {27'd0, count}, 0);
    load(8'h05, 8'h10, 8'h30, 1'b1, 1'b0);
    verify(8'h05, 8'h10);
    chk("gap_done", {31'd0, done}, 1);
    chk("gap_err", {31'd0, err}, 0);
    pulse_start();
    n_wr = 0;
    for (int i = 0; i < 5; i++) send(8'(i), 0);
    in_valid = 1'b0;
    tick();
    chk("mid_count", {27'd0, count}, 5);
    chk("mid_writes", n_wr, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort_hold", {31'd0, cpu_hold}, 0);
    chk("abort_ready", {31'd0, in_ready}, 0);
    chk("abort_count", {27'd0, count}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    pulse_start();
    load(8'h00, 8'h01, 8'h88, 1'b0, 1'b0);
    verify(8'h00, 8'h01);
    chk("reload_done", {31'd0, done}, 1);
    chk("reload_count", {27'd0, count}, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
